// File: rtl/mig_stream_scheduler.sv
// mig_stream_scheduler: arbitrates one write and one read phrase stream onto a single MIG UI, frame-ring addressed, credit-limited reads
// Ports: clk_in/rst_in (sync, active-high); wr_valid_in/wr_ready_out/wr_data_in/wr_tuser_in write stream;
//        rd_enable_in/rd_credit_in read control; rd_valid_out/rd_data_out/rd_tuser_out read stream;
//        app_* MIG user interface. SCHED_STATS_EN adds wr_count_out/rd_count_out/stall_count_out.
module mig_stream_scheduler #(
    parameter int ADDR_W        = 27,
    parameter int FRAME_PHRASES = 57600,
    parameter int ADDR_STEP     = 8,
    parameter int BURST_LEN     = 8,
    parameter int RD_CREDITS    = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [127:0]      wr_data_in,
    input  logic              wr_tuser_in,
    input  logic              rd_enable_in,
    input  logic              rd_credit_in,
    output logic              rd_valid_out,
    output logic [127:0]      rd_data_out,
    output logic              rd_tuser_out,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [127:0]      app_wdf_data,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]       wr_count_out,
    output logic [31:0]       rd_count_out,
    output logic [31:0]       stall_count_out
`endif
);
    localparam int IW = FRAME_PHRASES > 1 ? $clog2(FRAME_PHRASES) : 1;
    localparam int CW = $clog2(RD_CREDITS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_PHRASES - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t state_q, state_d;
    logic last_rd_q, last_rd_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, ret_idx_q, ret_idx_d;
    logic [CW-1:0] credits_q, credits_d;
    logic rd_valid_q, rd_valid_d, rd_tuser_q, rd_tuser_d;
    logic [127:0] rd_data_q, rd_data_d;
    logic wr_elig, rd_elig, wr_acc, rd_acc, burst_done;

    always_comb begin
        wr_elig = wr_valid_in;
        rd_elig = rd_enable_in && credits_q != '0;
        wr_ready_out = state_q == WR && app_rdy && app_wdf_rdy;
        app_en = state_q == WR ? wr_valid_in : state_q == RD && rd_elig;
        app_wdf_wren = state_q == WR && wr_valid_in;
        app_wdf_end = app_wdf_wren;
        app_wdf_data = wr_data_in;
        app_cmd = state_q == RD ? 3'b001 : 3'b000;
        // A frame-start phrase always lands at the ring origin
        app_addr = state_q == RD ? ADDR_W'(rd_idx_q) * STEP :
                   (state_q != WR || wr_tuser_in) ? '0 : ADDR_W'(wr_idx_q) * STEP;
        wr_acc = wr_valid_in && wr_ready_out;
        rd_acc = state_q == RD && app_en && app_rdy;
        burst_done = burst_q == BW'(BURST_LEN - 1);
        state_d = state_q;
        last_rd_d = last_rd_q;
        burst_d = burst_q + BW'(wr_acc || rd_acc);
        if (state_q == IDLE) begin
            burst_d = '0;
            if (wr_elig && (!rd_elig || last_rd_q)) begin
                state_d = WR;
                last_rd_d = 1'b0;
            end else if (rd_elig) begin
                state_d = RD;
                last_rd_d = 1'b1;
            end
        end else if (state_q == WR) begin
            if (!wr_elig || (wr_acc && burst_done)) state_d = IDLE;
        end else if (!rd_elig || (rd_acc && burst_done)) begin
            state_d = IDLE;
        end
        wr_idx_d = !wr_acc ? wr_idx_q : wr_tuser_in ? IW'(1) :
                   wr_idx_q == LAST_IDX ? '0 : wr_idx_q + IW'(1);
        rd_idx_d = !rd_acc ? rd_idx_q : rd_idx_q == LAST_IDX ? '0 : rd_idx_q + IW'(1);
        ret_idx_d = !app_rd_data_valid ? ret_idx_q : ret_idx_q == LAST_IDX ? '0 : ret_idx_q + IW'(1);
        // Simultaneous accept and credit cancel; a credit beyond the FIFO depth is dropped
        credits_d = rd_acc && !rd_credit_in ? credits_q - CW'(1) :
                    !rd_acc && rd_credit_in && credits_q != CW'(RD_CREDITS) ? credits_q + CW'(1) : credits_q;
        rd_valid_d = app_rd_data_valid;
        rd_data_d = app_rd_data;
        rd_tuser_d = app_rd_data_valid && ret_idx_q == '0;
        rd_valid_out = rd_valid_q;
        rd_data_out = rd_data_q;
        rd_tuser_out = rd_tuser_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            last_rd_q <= 1'b1;
            burst_q <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            ret_idx_q <= '0;
            credits_q <= CW'(RD_CREDITS);
            rd_valid_q <= 1'b0;
            rd_data_q <= '0;
            rd_tuser_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_rd_q <= last_rd_d;
            burst_q <= burst_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            ret_idx_q <= ret_idx_d;
            credits_q <= credits_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q <= rd_data_d;
            rd_tuser_q <= rd_tuser_d;
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q + 32'(wr_acc);
        rd_cnt_d = rd_cnt_q + 32'(rd_acc);
        stall_cnt_d = stall_cnt_q + 32'(app_en && !app_rdy);
        wr_count_out = wr_cnt_q;
        rd_count_out = rd_cnt_q;
        stall_count_out = stall_cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_mig_stream_scheduler.sv
// tb_mig_stream_scheduler: directed self-checking bench for mig_stream_scheduler
module tb_mig_stream_scheduler;
    logic clk_in = 1'b0;
    logic rst_in;
    logic wr_valid_in, wr_ready_out, wr_tuser_in;
    logic [127:0] wr_data_in;
    logic rd_enable_in, rd_credit_in, rd_valid_out, rd_tuser_out;
    logic [127:0] rd_data_out;
    logic [26:0] app_addr;
    logic [2:0] app_cmd;
    logic app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_wdf_data, app_rd_data;
`ifdef SCHED_STATS_EN
    logic [31:0] wr_count_out, rd_count_out, stall_count_out;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int i, k;
    int tuser_addr[8] = '{0, 8, 16, 24, 32, 0, 8, 16};

    always #5 clk_in = ~clk_in;

    mig_stream_scheduler #(.FRAME_PHRASES(24), .RD_CREDITS(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out), .wr_data_in(wr_data_in), .wr_tuser_in(wr_tuser_in),
        .rd_enable_in(rd_enable_in), .rd_credit_in(rd_credit_in),
        .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out), .rd_tuser_out(rd_tuser_out),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
`ifdef SCHED_STATS_EN
        ,
        .wr_count_out(wr_count_out), .rd_count_out(rd_count_out), .stall_count_out(stall_count_out)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        wr_valid_in = 1'b0;
        wr_data_in = '0;
        wr_tuser_in = 1'b0;
        rd_enable_in = 1'b0;
        rd_credit_in = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data = '0;
        app_rd_data_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_wrdy", wr_ready_out, 0);
        check("rst_addr", app_addr, 0);
        check("rst_rv", rd_valid_out, 0);
        check("rst_rtu", rd_tuser_out, 0);
        step();

        // 20 writes: bursts of 8 with one idle cycle between grants
        do_reset();
        i = 0;
        for (int c = 0; c < 23; c++) begin
            wr_valid_in = i < 20;
            wr_data_in = {4{32'hA5000000 + 32'(i)}};
            #1;
            check("w_en", app_en, c % 9 != 0);
            check("w_rdy", wr_ready_out, c % 9 != 0);
            if (app_en && wr_ready_out) begin
                check("w_addr", app_addr, 128'(i * 8));
                check("w_data", app_wdf_data, {4{32'hA5000000 + 32'(i)}});
                check("w_end", app_wdf_end, 1);
                i++;
            end
            step();
        end
        check("w_total", i, 20);
        wr_valid_in = 1'b0;

        // Frame start on phrase 5 rewinds the write address
        do_reset();
        i = 0;
        for (int c = 0; c < 9; c++) begin
            wr_valid_in = 1'b1;
            wr_tuser_in = i == 5;
            wr_data_in = {4{32'hB0000000 + 32'(i)}};
            #1;
            check("t_en", app_en, c != 0);
            if (c != 0) begin
                check("t_addr", app_addr, 128'(tuser_addr[i]));
                i++;
            end
            step();
        end
        wr_valid_in = 1'b0;
        wr_tuser_in = 1'b0;

        // 26 reads with continuous credit return, wrapping at 24 phrases
        do_reset();
        k = 0;
        rd_credit_in = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rd_enable_in = k < 26;
            #1;
            check("r_en", app_en, c % 9 != 0);
            if (app_en) begin
                check("r_cmd", app_cmd, 1);
                check("r_addr", app_addr, 128'((k % 24) * 8));
                k++;
            end
            step();
        end
        check("r_total", k, 26);
        rd_enable_in = 1'b0;
        rd_credit_in = 1'b0;
        for (int r = 0; r < 26; r++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = {4{32'hD0000000 + 32'(r)}};
            step();
            check("ret_v", rd_valid_out, 1);
            check("ret_d", rd_data_out, {4{32'hD0000000 + 32'(r)}});
            check("ret_tu", rd_tuser_out, r % 24 == 0);
        end
        app_rd_data_valid = 1'b0;
        step();
        check("ret_idle_v", rd_valid_out, 0);
        check("ret_idle_tu", rd_tuser_out, 0);

        // Credit exhaustion; excess credits at full count are ignored
        do_reset();
        rd_credit_in = 1'b1;
        step();
        step();
        rd_credit_in = 1'b0;
        rd_enable_in = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (app_en && app_rdy) k++;
            step();
        end
        check("cr_reads", k, 4);
        check("cr_en_off", app_en, 0);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            rd_credit_in = c == 0;
            #1;
            if (app_en && app_rdy) k++;
            step();
        end
        check("cr_one_more", k, 1);
        rd_credit_in = 1'b0;
        rd_enable_in = 1'b0;

        // Both streams eligible: alternate WR/RD bursts of 8
        do_reset();
        wr_valid_in = 1'b1;
        rd_enable_in = 1'b1;
        rd_credit_in = 1'b1;
        i = 0;
        k = 0;
        for (int c = 0; c < 100; c++) begin
            wr_data_in = {4{32'(c)}};
            #1;
            check("a_en", app_en, c % 9 != 0);
            if (c % 9 != 0) check("a_cmd", app_cmd, 128'((c / 9) % 2));
            if (app_en) begin
                if (app_cmd == 3'b000) i++;
                else k++;
            end
            step();
        end
        check("a_wr", i, 48);
        check("a_rd", k, 40);
`ifdef SCHED_STATS_EN
        check("a_wr_cnt", wr_count_out, 48);
        check("a_rd_cnt", rd_count_out, 40);
`endif
        wr_valid_in = 1'b0;
        rd_enable_in = 1'b0;
        rd_credit_in = 1'b0;

        // Stall during a write burst, then reset mid-burst
        do_reset();
        wr_valid_in = 1'b1;
        wr_data_in = {4{32'hE0}};
        #1;
        check("s_idle", app_en, 0);
        step();
        wr_data_in = {4{32'hE1}};
        #1;
        check("s_a0", app_addr, 0);
        check("s_r0", wr_ready_out, 1);
        step();
        wr_data_in = {4{32'hE2}};
        app_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("s_en", app_en, 1);
            check("s_addr", app_addr, 8);
            check("s_data", app_wdf_data, {4{32'hE2}});
            check("s_rdy", wr_ready_out, 0);
            step();
        end
        app_rdy = 1'b1;
        #1;
        check("s_a1", app_addr, 8);
        check("s_r1", wr_ready_out, 1);
`ifdef SCHED_STATS_EN
        check("s_stall", stall_count_out, 5);
        check("s_wcnt", wr_count_out, 1);
`endif
        step();
        wr_data_in = {4{32'hE3}};
        #1;
        check("s_a2", app_addr, 16);
        step();
        rst_in = 1'b1;
        app_rd_data_valid = 1'b1;
        app_rd_data = {4{32'hFF}};
        step();
        check("x_en", app_en, 0);
        check("x_rdy", wr_ready_out, 0);
        check("x_rv", rd_valid_out, 0);
`ifdef SCHED_STATS_EN
        check("x_wcnt", wr_count_out, 0);
        check("x_stall", stall_count_out, 0);
`endif
        rst_in = 1'b0;
        app_rd_data_valid = 1'b0;
        #1;
        check("x_idle", app_en, 0);
        step();
        #1;
        check("x_en2", app_en, 1);
        check("x_addr", app_addr, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mig_stream_scheduler.md
# mig_stream_scheduler

Arbitrates the single MIG user interface between one write stream of 128-bit phrases (from the byte-to-phrase packer) and one read stream feeding the phrase-to-byte unpacker. Each stream gets its own frame-relative address counter that wraps at the frame size, so the DRAM acts as a one-frame ring. Reads are credit-limited so MIG read data, which cannot be backpressured, never overruns the downstream phrase FIFO. The frame-start flag is carried from the write tuser to the write address, and regenerated on the read side from the return count.

## Interface
- ADDR_W, 27: MIG app_addr width
- FRAME_PHRASES, 57600: phrases per frame; each counter wraps here
- ADDR_STEP, 8: app_addr increment per phrase (BL8, x16)
- BURST_LEN, 8: max commands per grant before re-arbitration
- RD_CREDITS, 16: downstream read FIFO depth in phrases
- clk_in  in  1  UI clock
- rst_in  in  1  synchronous, active-high reset
- wr_valid_in  in  1  write phrase valid
- wr_ready_out  out  1  write phrase accepted when high with wr_valid_in
- wr_data_in  in  128  write phrase
- wr_tuser_in  in  1  phrase begins a new frame
- rd_enable_in  in  1  permits issuing read commands
- rd_credit_in  in  1  one-cycle pulse per phrase popped from the downstream FIFO
- rd_valid_out  out  1  read phrase valid (no backpressure)
- rd_data_out  out  128  read phrase
- rd_tuser_out  out  1  phrase is frame phrase 0
- app_addr  out  ADDR_W  MIG address
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_en, app_wdf_wren, app_wdf_end  out  1  MIG strobes
- app_wdf_data  out  128  equals wr_data_in
- app_rdy, app_wdf_rdy  in  1  MIG ready
- app_rd_data  in  128; app_rd_data_valid  in  1  MIG read return

## Operation
- FSM has three states: IDLE, WR, RD. Reset state is IDLE, last_grant=RD, wr_idx=rd_idx=ret_idx=0, credits=RD_CREDITS, and all outputs 0.
- Write is eligible when wr_valid_in=1. Read is eligible when rd_enable_in=1 and credits>0.
- From IDLE: if only one request is eligible, grant it. If both are eligible, grant the one opposite last_grant. If neither is eligible, stay in IDLE. Granting records last_grant and clears burst_cnt.
- In WR: app_en=app_wdf_wren=app_wdf_end=wr_valid_in and app_cmd=000. Write acceptance is wr_valid_in & app_rdy & app_wdf_rdy, and wr_ready_out equals that expression with wr_valid_in removed (combinational).
- Write address: if wr_tuser_in=1, app_addr=0 and wr_idx becomes 1 after acceptance. Otherwise app_addr=wr_idx*ADDR_STEP and wr_idx increments on acceptance, wrapping FRAME_PHRASES-1 → 0.
- In RD: app_en=1 while credits>0, with app_cmd=001 and app_addr=rd_idx*ADDR_STEP. A read command is accepted on app_en & app_rdy. rd_idx increments and wraps like wr_idx.
- A grant ends and the FSM returns to IDLE on the cycle after whichever comes first: burst_cnt reaching BURST_LEN accepts, or eligibility dropping. A held app_en must not be dropped while app_rdy=0 unless eligibility itself dropped.
- Credits: decrement on read accept, increment on rd_credit_in. If both happen in the same cycle, credits are unchanged. Credits never exceed RD_CREDITS; an excess credit pulse is ignored.
- Read return: registered pass-through. rd_valid_out and rd_data_out follow app_rd_data_valid and app_rd_data by one cycle. rd_tuser_out=(ret_idx==0). ret_idx increments per return and wraps at FRAME_PHRASES.
- Address arithmetic uses ADDR_W bits. The product FRAME_PHRASES*ADDR_STEP fits in ADDR_W.

## Timing
- Write command latency is 0: the command is presented in the same cycle as the handshake.
- Grant switch costs 1 IDLE cycle, so back-to-back alternating bursts leave a 1-cycle command gap.
- Read data latency is app_rd_data_valid + 1 cycle.
- Reset mid-burst: the next cycle drops app_en and resets every index and credits. Read returns still in flight when reset is applied are discarded.

## Configuration
- SCHED_STATS_EN defined: adds output ports wr_count_out[31:0], rd_count_out[31:0] and stall_count_out[31:0].
  - wr_count_out counts accepted writes; rd_count_out counts accepted reads.
  - stall_count_out counts cycles with app_en=1 and app_rdy=0.
  - All three reset to 0 and wrap on overflow.
- SCHED_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Only writes, 20 phrases, app_rdy=app_wdf_rdy=1, BURST_LEN=8 → addresses 0,8,…,152 with gaps after the 8th and 16th phrase. app_wdf_data must match input order.
- Write with wr_tuser_in on phrase 5 → that phrase goes to addr 0 and the next to addr 8.
- FRAME_PHRASES=4, 10 reads, credits replenished each cycle → addresses 0,8,16,24,0,8,…. rd_tuser_out=1 on returns 0, 4 and 8.
- RD_CREDITS=4, no rd_credit_in → exactly 4 read commands, then app_en=0. One credit pulse → exactly one more read.
- Writes and reads both eligible continuously → grants alternate RD/WR in bursts of 8, with no starvation over 100 cycles.
- app_rdy held 0 for 5 cycles during WR → app_addr and data stay stable and wr_ready_out=0. With SCHED_STATS_EN, stall_count_out=5. rst_in asserted mid-burst → app_en=0 on the next cycle and counters reset.
